// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared defaults and helpers for the pipeline block family.
//               Holds default operand width, output buffer depth and shared
//               resource latency, and the width helper used to size
//               occupancy/credit counters so they can represent 0..DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_RES_LAT = 1;

    // A counter holding 0..depth inclusive needs clog2(depth+1) bits.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipe_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fifo
// Description : DEPTH x DATA_W circular buffer with wrap-around pointers.
//               Push and pop may happen together at any fill level,
//               including full and empty. There is no bypass: a push into
//               an empty buffer shows up on pop_data/empty the next cycle.
//               clear empties the buffer on the next edge and takes
//               priority over a push or pop in the same cycle.
// Ports       : clk, reset      - clock / async active-high reset
//               clear           - synchronous discard of all entries
//               push, push_data - write request and data
//               pop             - read request (ignored while empty)
//               pop_data        - head entry, 0 while empty
//               count           - registered entry count (0..DEPTH)
//               empty           - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fifo
    import pipeline_pkg::*;
#(
    parameter int  DATA_W = DEFAULT_DATA_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic w_full;
    logic w_pop_en;
    logic w_push_en;

    assign empty     = (count_q == '0);
    assign w_full    = (count_q == CNT_W'(DEPTH));
    assign w_pop_en  = pop && !empty && !clear;
    // A pop in the same cycle frees the slot, so push-on-full is legal then.
    assign w_push_en = push && (!w_full || w_pop_en) && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({w_push_en, w_pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule : pipe_fifo
`default_nettype wire

// File: rtl/pipeline_stage_arb.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_arb
// Description : Pipeline stage sharing one resource through an external
//               arbiter. A single hold register takes operands on a
//               valid/ready input and requests the resource; a granted
//               request issues the operand. A RES_LAT-deep valid shift
//               register tracks issued work, and when its top bit arrives
//               resource_output is pushed into a DEPTH-entry output buffer
//               that drains on a valid/ready output. A request is only
//               raised when buffered plus in-flight results leave a free
//               slot, so every issued result is guaranteed a place.
//               flush discards held, in-flight and buffered work.
// Ports       : clk, reset           - clock / async active-high reset
//               in_data/valid/ready  - operand input handshake
//               flush                - synchronous discard of all work
//               out_data/valid/ready - result output handshake
//               arbiter_req/grant    - shared resource arbitration
//               resource_input       - operand to resource (issue cycle)
//               resource_output      - result, sampled RES_LAT after issue
//               stall                - held operand not issuing this cycle
//               occupancy            - registered output buffer count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_arb
    import pipeline_pkg::*;
#(
    parameter int  DATA_W  = DEFAULT_DATA_W,
    parameter int  DEPTH   = DEFAULT_DEPTH,
    parameter int  RES_LAT = DEFAULT_RES_LAT,
    localparam int CNT_W   = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              arbiter_req,
    input  logic              arbiter_grant,
    output logic [DATA_W-1:0] resource_input,
    input  logic [DATA_W-1:0] resource_output,
    output logic              stall,
    output logic [CNT_W-1:0]  occupancy
);

    // One extra bit so occupancy + in-flight never wraps before the compare.
    localparam int SUM_W = CNT_W + 1;

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q,  hold_data_d;
    logic [RES_LAT-1:0] inflight_q,  inflight_d;

    logic [SUM_W-1:0]  w_inflight_cnt;
    logic [SUM_W-1:0]  w_credit_sum;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    // ------------------------------------------------------------------
    // Credit: both terms are registered, so a pop this cycle only frees
    // credit from the next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RES_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + SUM_W'(inflight_q[i]);
        end
    end

    assign w_credit_sum = SUM_W'(w_fifo_count) + w_inflight_cnt;
    assign w_credit_ok  = (w_credit_sum < SUM_W'(DEPTH));

    // ------------------------------------------------------------------
    // Request / issue / acceptance
    // ------------------------------------------------------------------
    assign arbiter_req    = hold_valid_q && w_credit_ok && !flush;
    assign w_issue        = arbiter_req && arbiter_grant;
    // Accepting while issuing keeps one operand per cycle under a held grant.
    assign in_ready       = (!hold_valid_q || w_issue) && !flush;
    assign w_accept       = in_valid && in_ready;
    assign stall          = hold_valid_q && !w_issue;
    assign resource_input = hold_valid_q ? hold_data_q : '0;

    // ------------------------------------------------------------------
    // Hold register
    // ------------------------------------------------------------------
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (w_accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
        end else if (w_issue) begin
            hold_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking: bit 0 marks an issue, the top bit marks the
    // cycle the resource result must be captured.
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d    = inflight_q << 1;
        inflight_d[0] = w_issue;
        if (flush) begin
            inflight_d = '0;
        end
    end

    assign w_push = inflight_q[RES_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            inflight_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            inflight_q   <= inflight_d;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer; clear drops a result landing in the flush cycle and
    // cancels a pop in that cycle.
    // ------------------------------------------------------------------
    assign w_pop = out_valid && out_ready;

    pipe_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (w_push),
        .push_data (resource_output),
        .pop       (w_pop),
        .pop_data  (out_data),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    assign out_valid = !w_fifo_empty;
    assign occupancy = w_fifo_count;

endmodule : pipeline_stage_arb
`default_nettype wire

// File: tb/tb_pipeline_stage_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stage_arb
// Description : Self-checking bench for pipeline_stage_arb (DEPTH=4,
//               RES_LAT=2). A transaction-level reference model (held
//               operand, queue of issue timestamps, queue of buffered
//               results) predicts every output each cycle. Directed steps
//               cover reset, basic issue, withheld grant, credit limit,
//               wrap-around, flush and async reset; a random phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_arb;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int RES_LAT = 2;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              arbiter_req;
    logic              arbiter_grant;
    logic [DATA_W-1:0] resource_input;
    logic [DATA_W-1:0] resource_output;
    logic              stall;
    logic [CNT_W-1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    pipeline_stage_arb #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RES_LAT (RES_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .arbiter_req     (arbiter_req),
        .arbiter_grant   (arbiter_grant),
        .resource_input  (resource_input),
        .resource_output (resource_output),
        .stall           (stall),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- shared resource: doubling or identity ----------------
    bit res_mode = 1'b1;

    function automatic logic [DATA_W-1:0] fres(input bit m, input logic [DATA_W-1:0] d);
        return m ? (d << 1) : d;
    endfunction

    logic [DATA_W-1:0] res_pipe [RES_LAT];
    always @(posedge clk) begin
        res_pipe[0] <= (arbiter_req && arbiter_grant) ? fres(res_mode, resource_input)
                                                      : 32'hDEAD_BEEF;
        for (int i = 1; i < RES_LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end
    assign resource_output = res_pipe[RES_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int                t;
        logic [DATA_W-1:0] v;
    } flight_t;

    bit                m_hold;
    logic [DATA_W-1:0] m_hold_data;
    flight_t           m_fl[$];
    logic [DATA_W-1:0] m_buf[$];
    logic [DATA_W-1:0] obs_q[$];
    int                cyc = 0;
    bit                last_acc;
    int                issue_cnt = 0;
    int                stall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_hold = 1'b0;
        m_fl.delete();
        m_buf.delete();
    endtask

    // One clock cycle: check at the falling edge, advance model, return
    // just after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit credit, req, iss, rdy, pop, land, acc;
        logic [DATA_W-1:0] hd;
        @(negedge clk);
        credit = (m_buf.size() + m_fl.size()) < DEPTH;
        req    = m_hold && credit && !flush;
        iss    = req && arbiter_grant;
        rdy    = (!m_hold || iss) && !flush;
        chk("arbiter_req",    arbiter_req,    req);
        chk("in_ready",       in_ready,       rdy);
        chk("stall",          stall,          m_hold && !iss);
        chk("resource_input", resource_input, m_hold ? m_hold_data : '0);
        chk("out_valid",      out_valid,      m_buf.size() > 0);
        chk("out_data",       out_data,       (m_buf.size() > 0) ? m_buf[0] : '0);
        chk("occupancy",      occupancy,      m_buf.size());
        if (arbiter_req && arbiter_grant) issue_cnt++;
        if (stall) stall_cnt++;
        pop  = (m_buf.size() > 0) && out_ready;
        land = (m_fl.size() > 0) && (m_fl[0].t + RES_LAT == cyc);
        acc  = in_valid && rdy;
        if (land && !flush)
            chk("overflow", (occupancy == CNT_W'(DEPTH)) && !(out_valid && out_ready), 1'b0);
        if (out_valid && out_ready && !flush) obs_q.push_back(out_data);
        if (flush) begin
            model_clear();
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (land) begin
                m_buf.push_back(m_fl[0].v);
                void'(m_fl.pop_front());
            end
            hd = m_hold_data;
            if (iss) begin
                m_fl.push_back('{t: cyc, v: fres(res_mode, hd)});
                m_hold = 1'b0;
            end
            if (acc) begin
                m_hold      = 1'b1;
                m_hold_data = in_data;
            end
        end
        last_acc = acc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Streams n operands starting at first, one per accepted handshake.
    task automatic stream(input logic [DATA_W-1:0] first, input int n);
        logic [DATA_W-1:0] d;
        int sent;
        int guard;
        d     = first;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 200) begin
            in_valid = 1'b1;
            in_data  = d;
            cycle();
            if (last_acc) begin
                sent++;
                d++;
            end
            guard++;
        end
        in_valid = 1'b0;
        chk("stream_sent", sent, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_issue;
        int base_stall;

        // ---------------- reset ----------------
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        out_ready = 1'b0; arbiter_grant = 1'b0;
        model_clear();
        #3;
        chk("rst_req",    arbiter_req,    1'b0);
        chk("rst_ovalid", out_valid,      1'b0);
        chk("rst_occ",    occupancy,      '0);
        chk("rst_stall",  stall,          1'b0);
        chk("rst_odata",  out_data,       '0);
        chk("rst_rin",    resource_input, '0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // ---------------- basic issue (doubling resource) ----------------
        res_mode = 1'b1; arbiter_grant = 1'b1;
        in_valid = 1'b1; in_data = 32'h11;
        cycle();
        idle(3);
        chk("basic_ovalid", out_valid, 1'b1);
        chk("basic_odata",  out_data,  32'h22);
        chk("basic_occ",    occupancy, 1);
        out_ready = 1'b1;
        idle(2);

        // ---------------- grant withheld 5 cycles ----------------
        arbiter_grant = 1'b0;
        in_valid = 1'b1; in_data = 32'h33;
        cycle();
        in_valid = 1'b1; in_data = 32'h34;
        base_stall = stall_cnt;
        for (int i = 0; i < 5; i++) cycle();
        chk("withheld_stalls", stall_cnt - base_stall, 5);
        in_valid = 1'b0;
        arbiter_grant = 1'b1;
        idle(6);

        // ---------------- credit backpressure ----------------
        res_mode = 1'b0; out_ready = 1'b0;
        base_issue = issue_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h100 + i;
            cycle();
        end
        in_valid = 1'b0;
        idle(3);
        chk("credit_issues", issue_cnt - base_issue, 4);
        chk("credit_occ",    occupancy, 4);
        chk("credit_stall",  stall, 1'b1);
        chk("credit_req",    arbiter_req, 1'b0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        idle(4);
        chk("credit_one_more", issue_cnt - base_issue, 5);
        out_ready = 1'b1;
        idle(12);

        // ---------------- wrap-around, out_ready toggling ----------------
        obs_q.delete();
        res_mode = 1'b0;
        begin
            logic [DATA_W-1:0] d;
            int sent;
            d = 32'h1; sent = 0;
            for (int i = 0; i < 60 && sent < 10; i++) begin
                out_ready = i[0];
                in_valid  = 1'b1;
                in_data   = d;
                cycle();
                if (last_acc) begin
                    sent++;
                    d++;
                end
            end
            in_valid = 1'b0;
            for (int i = 0; i < 30; i++) begin
                out_ready = i[0];
                cycle();
            end
        end
        chk("wrap_count", obs_q.size(), 10);
        for (int i = 0; i < 10 && i < obs_q.size(); i++)
            chk("wrap_order", obs_q[i], i + 1);

        // ---------------- flush with held, in-flight and buffered ----------------
        out_ready = 1'b0;
        stream(32'hA0, 2);
        idle(4);
        stream(32'hB0, 3);
        chk("pre_flush_hold", stall, 1'b1);
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_occ",    occupancy,   0);
        chk("flush_ovalid", out_valid,   1'b0);
        chk("flush_req",    arbiter_req, 1'b0);
        obs_q.delete();
        idle(6);
        stream(32'h55, 1);
        idle(6);
        chk("post_flush_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("post_flush_data", obs_q[0], 32'h55);

        // ---------------- random phase ----------------
        res_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 9) < 7);
            in_data       = $urandom;
            arbiter_grant = ($urandom_range(0, 9) < 6);
            out_ready     = ($urandom_range(0, 1) == 1);
            flush         = ($urandom_range(0, 99) < 3);
            cycle();
        end
        flush = 1'b0; arbiter_grant = 1'b1; out_ready = 1'b1;
        idle(15);
        chk("drain_occ", occupancy, 0);

        // ---------------- async reset mid-stream ----------------
        out_ready = 1'b0; arbiter_grant = 1'b1; res_mode = 1'b0;
        stream(32'hC0, 4);
        in_valid = 1'b1; in_data = 32'hC8;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_req",    arbiter_req, 1'b0);
        chk("areset_ovalid", out_valid,   1'b0);
        chk("areset_occ",    occupancy,   0);
        model_clear();
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("areset_in_ready", in_ready,       1'b1);
        chk("areset_rin",      resource_input, '0);
        chk("areset_stall",    stall,          1'b0);
        obs_q.delete();
        out_ready = 1'b1;
        idle(1);
        stream(32'h77, 1);
        idle(6);
        chk("areset_fresh_cnt", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("areset_fresh_data", obs_q[0], 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipeline_stage_arb
`default_nettype wire
